excitation_source: RTL and testbench

- Upstream stage of the 12th-order all-pole vocal-tract filter.
- Produces the scaled 16-bit excitation sample and the start pulse the filter consumes, once per sample period.
- Voiced frames produce a pitch pulse train; unvoiced frames (period = 0) produce LFSR noise.
- Paces the filter with a free-running sample-rate divider and a start/done handshake.

---
 rtl/excitation_source.sv | 164 ++++++++++++++++
 tb/tb_excitation_source.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/excitation_source.sv
// excitation_source: pitch-pulse / LFSR-noise excitation generator that paces the
// all-pole vocal-tract filter. Define EXC_OVERRUN_DROP_EN to drop overrun samples.
module excitation_source #(
    parameter int unsigned SAMPLE_DIV = 250,
    parameter logic [16:0] LFSR_SEED  = 17'h00001
) (
    input  logic               clk,
    input  logic               rst_an,
    input  logic [7:0]         period_i,
    input  logic [7:0]         amplitude_i,
    input  logic               params_load_i,
    input  logic               filt_done_i,
    output logic               filt_start_o,
    output logic signed [15:0] sig_out_o,
    output logic               sample_tick_o,
    output logic               overrun_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        GUARD = 2'd2,
        BUSY  = 2'd3
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

    logic [15:0] divCnt_q, divCnt_d;
    logic        tick_q;
    logic [7:0]  activePeriod_q, activePeriod_d;
    logic [7:0]  activeAmp_q, activeAmp_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic [16:0] lfsr_q, lfsr_d;
    logic [15:0] sample_q, sample_d;
    logic [15:0] noiseMag;
    logic        wrap;
    logic        overrunTick;
    state_t      state_q;
    logic        filtStart_q;
`ifdef EXC_OVERRUN_DROP_EN
    logic        overrun_q;
`else
    logic        pending_q;
`endif

    assign wrap        = (divCnt_q == DIV_LAST);
    assign overrunTick = tick_q && (state_q != IDLE);

    always_comb begin
        divCnt_d       = wrap ? 16'd0 : divCnt_q + 16'd1;
        activePeriod_d = params_load_i ? period_i : activePeriod_q;
        activeAmp_d    = params_load_i ? amplitude_i : activeAmp_q;
    end

    // Generation happens at the divider wrap edge, so a load in that same cycle
    // is still invisible here and only takes effect from the following tick.
    always_comb begin
        sample_d = sample_q;
        pcnt_d   = pcnt_q;
        lfsr_d   = lfsr_q;
        noiseMag = {3'b000, activeAmp_q, 5'b00000};
        if (wrap) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]};
            if (activePeriod_q != 8'd0) begin
                if (pcnt_q == 8'd0) begin
                    sample_d = {1'b0, activeAmp_q, 7'b0000000};
                    pcnt_d   = activePeriod_q - 8'd1;
                end else begin
                    sample_d = 16'd0;
                    pcnt_d   = pcnt_q - 8'd1;
                end
            end else begin
                sample_d = lfsr_q[0] ? noiseMag : (16'd0 - noiseMag);
            end
        end
        // Leaving a noise frame restarts the pulse train on the very next tick.
        if (params_load_i && (activePeriod_q == 8'd0) && (period_i != 8'd0)) begin
            pcnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            divCnt_q       <= 16'd0;
            tick_q         <= 1'b0;
            activePeriod_q <= 8'd0;
            activeAmp_q    <= 8'd0;
            pcnt_q         <= 8'd0;
            lfsr_q         <= LFSR_SEED;
            sample_q       <= 16'd0;
        end else begin
            divCnt_q       <= divCnt_d;
            tick_q         <= wrap;
            activePeriod_q <= activePeriod_d;
            activeAmp_q    <= activeAmp_d;
            pcnt_q         <= pcnt_d;
            lfsr_q         <= lfsr_d;
            sample_q       <= sample_d;
        end
    end

    // GUARD exists because the filter's done is still high in the cycle after start.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q     <= IDLE;
            filtStart_q <= 1'b0;
`ifdef EXC_OVERRUN_DROP_EN
            overrun_q   <= 1'b0;
`else
            pending_q   <= 1'b0;
`endif
        end else begin
            filtStart_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick_q && filt_done_i) begin
                        state_q     <= START;
                        filtStart_q <= 1'b1;
                    end
                end
                START: state_q <= GUARD;
                GUARD: state_q <= BUSY;
                BUSY: begin
                    if (filt_done_i) begin
`ifdef EXC_OVERRUN_DROP_EN
                        state_q <= IDLE;
`else
                        if (pending_q || overrunTick) begin
                            state_q     <= START;
                            filtStart_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef EXC_OVERRUN_DROP_EN
            if (overrunTick) begin
                overrun_q <= 1'b1;
            end else if (params_load_i) begin
                overrun_q <= 1'b0;
            end
`else
            if ((state_q == BUSY) && filt_done_i) begin
                pending_q <= 1'b0;
            end else if (overrunTick) begin
                pending_q <= 1'b1;
            end
`endif
        end
    end

    assign filt_start_o  = filtStart_q;
    assign sig_out_o     = sample_q;
    assign sample_tick_o = tick_q;
`ifdef EXC_OVERRUN_DROP_EN
    assign overrun_o     = overrun_q;
`else
    assign overrun_o     = 1'b0;
`endif

endmodule

// File: tb/tb_excitation_source.sv
// tb_excitation_source: scoreboard bench for excitation_source with a per-tick reference
// model, a model filter with a configurable busy time, and randomized parameter loads.
module tb_excitation_source;

    localparam int DIV         = 32;
    localparam int NORMAL_HOLD = 3;
    localparam int NOISE_LEN   = 1024;

    typedef struct {
        int val;
        bit timed;
    } startExp_t;

    logic               clk = 1'b0;
    logic               rst_an = 1'b0;
    logic [7:0]         periodIn = 8'd0;
    logic [7:0]         ampIn = 8'd0;
    logic               paramsLoad = 1'b0;
    logic               filtDone = 1'b1;
    logic               filtStart;
    logic signed [15:0] sigOut;
    logic               sampleTick;
    logic               overrun;

    int assertCount = 0;
    int failCount   = 0;

    bit        noiseBits [NOISE_LEN];
    int        sampleQ[$];
    startExp_t startQ[$];

    int edgeNum = 0;
    int tickIdx = 0;
    bit expTickVis = 1'b0;
    int mPeriod = 0;
    int mAmp = 0;
    int mPcnt = 0;
    int mSample = 0;
    bit expOv = 1'b0;
    bit ovSetNext = 1'b0;
    startExp_t pushExp;

    bit filtArmed = 1'b0;
    int busyCnt = 0;
    int holdLen = NORMAL_HOLD;

    int negCnt = 0;
    int lastTickNeg = 0;
    startExp_t popExp;

    excitation_source #(
        .SAMPLE_DIV(DIV),
        .LFSR_SEED (17'h00001)
    ) dut (
        .clk          (clk),
        .rst_an       (rst_an),
        .period_i     (periodIn),
        .amplitude_i  (ampIn),
        .params_load_i(paramsLoad),
        .filt_done_i  (filtDone),
        .filt_start_o (filtStart),
        .sig_out_o    (sigOut),
        .sample_tick_o(sampleTick),
        .overrun_o    (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // The noise reference is the m-sequence of x^17+x^14+1 itself: bit t is lfsr[0] at tick t.
    task automatic buildNoise();
        logic [16:0] seed;
        seed = 17'h00001;
        for (int i = 0; i < 17; i++) noiseBits[i] = seed[i];
        for (int i = 17; i < NOISE_LEN; i++) noiseBits[i] = noiseBits[i-17] ^ noiseBits[i-14];
    endtask

    task automatic waitTicks(input int n);
        repeat (n * DIV) @(negedge clk);
    endtask

    task automatic applyStimulus(input int p, input int a, input int offset);
        for (int i = 0; i < 2 * DIV && (edgeNum % DIV) != offset; i++) @(negedge clk);
        periodIn   = 8'(p);
        ampIn      = 8'(a);
        paramsLoad = 1'b1;
        @(negedge clk);
        paramsLoad = 1'b0;
    endtask

    // Reference model: one sample per tick computed from the active parameters;
    // loads seen at a generation edge apply only after that edge's sample.
    always @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            edgeNum    = 0;
            tickIdx    = 0;
            expTickVis = 1'b0;
            mPeriod    = 0;
            mAmp       = 0;
            mPcnt      = 0;
            expOv      = 1'b0;
            ovSetNext  = 1'b0;
            sampleQ.delete();
            startQ.delete();
        end else begin
            edgeNum++;
            expTickVis = (edgeNum % DIV) == 0;
            if (ovSetNext) expOv = 1'b1;
            else if (paramsLoad) expOv = 1'b0;
            ovSetNext = 1'b0;
            if (expTickVis) begin
                if (mPeriod != 0) begin
                    mSample = (mPcnt == 0) ? mAmp * 128 : 0;
                    mPcnt   = (mPcnt == 0) ? mPeriod - 1 : mPcnt - 1;
                end else begin
                    mSample = (tickIdx < NOISE_LEN && noiseBits[tickIdx]) ? mAmp * 32 : -(mAmp * 32);
                end
                tickIdx++;
                sampleQ.push_back(mSample);
                pushExp.val = mSample;
                if (filtDone && !filtArmed && startQ.size() == 0) begin
                    pushExp.timed = 1'b1;
                    startQ.push_back(pushExp);
                end else begin
`ifdef EXC_OVERRUN_DROP_EN
                    ovSetNext = 1'b1;
`else
                    pushExp.timed = 1'b0;
                    if (startQ.size() > 0 && !startQ[startQ.size()-1].timed) void'(startQ.pop_back());
                    startQ.push_back(pushExp);
`endif
                end
            end
            if (paramsLoad) begin
                if (mPeriod == 0 && periodIn != 8'd0) mPcnt = 0;
                mPeriod = int'(periodIn);
                mAmp    = int'(ampIn);
            end
        end
    end

    // Model filter: done stays high one cycle after start, then low for holdLen cycles.
    always @(negedge clk or negedge rst_an) begin
        if (!rst_an) begin
            filtDone  = 1'b1;
            filtArmed = 1'b0;
            busyCnt   = 0;
        end else if (filtArmed) begin
            filtArmed = 1'b0;
            filtDone  = 1'b0;
            busyCnt   = holdLen;
            holdLen   = NORMAL_HOLD;
        end else if (filtStart) begin
            filtArmed = 1'b1;
        end else if (busyCnt > 0) begin
            busyCnt--;
            if (busyCnt == 0) filtDone = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_an) begin
            negCnt++;
            if (sampleTick || expTickVis) begin
                checkOutput("sample_tick timing", sampleTick, expTickVis);
                if (expTickVis) begin
                    lastTickNeg = negCnt;
                    if (sampleQ.size() > 0) checkOutput("sig_out at tick", sigOut, sampleQ.pop_front());
                    else checkOutput("model sample available", sampleQ.size(), 1);
                    checkOutput("overrun at tick", overrun, expOv);
                end
            end
            if (filtStart) begin
                if (startQ.size() > 0) begin
                    popExp = startQ.pop_front();
                    checkOutput("sig_out at filt_start", sigOut, popExp.val);
                    if (popExp.timed) checkOutput("filt_start latency", negCnt - lastTickNeg, 1);
                end else begin
                    checkOutput("unexpected filt_start", startQ.size(), 1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        buildNoise();
        repeat (3) @(negedge clk);
        checkOutput("reset sig_out", sigOut, 0);
        checkOutput("reset filt_start", filtStart, 0);
        checkOutput("reset sample_tick", sampleTick, 0);
        checkOutput("reset overrun", overrun, 0);
        rst_an = 1'b1;

        waitTicks(2);
        applyStimulus(3, 100, 10);
        waitTicks(6);
        applyStimulus(0, 10, 10);
        waitTicks(200);
        applyStimulus(5, 50, 7);
        waitTicks(3);
        applyStimulus(2, 20, DIV - 1);
        waitTicks(3);
        applyStimulus(4, 200, 0);
        waitTicks(3);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(int'($urandom_range(0, 6)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, DIV - 1)));
            waitTicks(int'($urandom_range(1, 3)));
        end

        applyStimulus(1, 77, 10);
        holdLen = (3 * DIV) / 2;
        waitTicks(4);
        checkOutput("overrun after busy filter", overrun, expOv);
        applyStimulus(1, 77, 10);
        @(negedge clk);
        checkOutput("overrun after load", overrun, expOv);
        waitTicks(2);

        checkOutput("start queue drained", startQ.size(), 0);
        checkOutput("final overrun", overrun, expOv);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
